exec_sequencer: RTL and testbench

Parametrised second-generation control FSM for the processor controlpath. Sequences fetch, load/store wait, execute and trap. Adds features the first-generation FSM lacks: multi-cycle execute, configurable memory-wait timeout, a latched trap cause with acknowledge, and a retired-instruction counter. Sits between the instruction/MMU decoders and the datapath; its outputs gate pc_inc, register write and ld/st strobes.

---
 rtl/exec_sequencer_if.sv | 43 ++++
 rtl/exec_sequencer.sv | 164 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - decoder/datapath-facing signal bundle of the execution sequencer
interface exec_sequencer_if #(
    parameter int CYC_W = 3,
    parameter int CNT_W = 32
);
    // Requests and status from decoders, memories and host
    logic             i_go;
    logic             i_halt;
    logic             i_wait_instr;
    logic             i_instr_segv;
    logic             i_wait_data;
    logic             i_data_segv;
    logic             i_invalid_instruction;
    logic             i_ld;
    logic             i_st;
    logic [CYC_W-1:0] i_alu_cycles;
    logic             i_trap_ack;

    // Sequencer state and datapath strobes
    logic [4:0]       o_state;
    logic             o_fetch_en;
    logic             o_ld_en;
    logic             o_st_en;
    logic             o_pc_inc;
    logic             o_reg_write_en;
    logic             o_busy;
    logic [2:0]       o_trap_cause;
    logic [CNT_W-1:0] o_instr_count;

    modport master (
        output i_go, i_halt, i_wait_instr, i_instr_segv, i_wait_data, i_data_segv,
               i_invalid_instruction, i_ld, i_st, i_alu_cycles, i_trap_ack,
        input  o_state, o_fetch_en, o_ld_en, o_st_en, o_pc_inc, o_reg_write_en,
               o_busy, o_trap_cause, o_instr_count
    );

    modport slave (
        input  i_go, i_halt, i_wait_instr, i_instr_segv, i_wait_data, i_data_segv,
               i_invalid_instruction, i_ld, i_st, i_alu_cycles, i_trap_ack,
        output o_state, o_fetch_en, o_ld_en, o_st_en, o_pc_inc, o_reg_write_en,
               o_busy, o_trap_cause, o_instr_count
    );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - fetch/wait/execute/trap control FSM with timeout, trap cause and retire counter
module exec_sequencer #(
    parameter int CYC_W       = 3,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 200,
    parameter int CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    exec_sequencer_if.slave   bus
);

    typedef enum logic [4:0] {
        ST_HALT       = 5'b00000,
        ST_READ_INS   = 5'b01000,
        ST_WAIT_LOAD  = 5'b01010,
        ST_WAIT_STORE = 5'b01100,
        ST_DO         = 5'b01001,
        ST_TRAP       = 5'b10000
    } state_t;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_INSTR_SEG = 3'd1;
    localparam logic [2:0] CAUSE_DATA_SEG  = 3'd2;
    localparam logic [2:0] CAUSE_INVALID   = 3'd3;
    localparam logic [2:0] CAUSE_FETCH_TMO = 3'd4;
    localparam logic [2:0] CAUSE_DATA_TMO  = 3'd5;

    // Zero disables the timeout entirely
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_MAX);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMEOUT_W-1:0] r_tmo_cnt;
    logic [TIMEOUT_W-1:0] w_tmo_nxt;
    logic [TIMEOUT_W-1:0] w_tmo_inc;
    logic                 w_tmo_hit;
    logic [CYC_W-1:0]     r_exec_cnt;
    logic [CYC_W-1:0]     w_exec_nxt;
    logic [2:0]           r_trap_cause;
    logic [2:0]           w_cause_nxt;
    logic [CNT_W-1:0]     r_instr_count;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 w_retire;

    // Saturating wait counter and the "this wait cycle reaches the limit" flag
    always_comb begin
        w_tmo_inc = (&r_tmo_cnt) ? r_tmo_cnt : r_tmo_cnt + TIMEOUT_W'(1);
        w_tmo_hit = (TMO_LIMIT != 32'd0) && (32'(w_tmo_inc) >= TMO_LIMIT);
    end

    // State and bookkeeping registers; reset aborts any in-flight instruction
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_HALT;
            r_tmo_cnt     <= '0;
            r_exec_cnt    <= '0;
            r_trap_cause  <= CAUSE_NONE;
            r_instr_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_tmo_cnt     <= w_tmo_nxt;
            r_exec_cnt    <= w_exec_nxt;
            r_trap_cause  <= w_cause_nxt;
            r_instr_count <= w_count_nxt;
        end
    end

    // Next-state logic; the timeout counter defaults to 0 so any state entry clears it
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = '0;
        w_exec_nxt  = r_exec_cnt;
        w_cause_nxt = r_trap_cause;
        w_count_nxt = r_instr_count;

        case (r_state)
            ST_HALT: begin
                if (bus.i_go && !bus.i_halt) begin
                    w_state_nxt = ST_READ_INS;
                    w_cause_nxt = CAUSE_NONE;
                end
            end

            ST_READ_INS: begin
                if (bus.i_instr_segv) begin
                    w_state_nxt = ST_TRAP;
                    w_cause_nxt = CAUSE_INSTR_SEG;
                end else if (bus.i_wait_instr) begin
                    if (w_tmo_hit) begin
                        w_state_nxt = ST_TRAP;
                        w_cause_nxt = CAUSE_FETCH_TMO;
                    end else begin
                        w_tmo_nxt = w_tmo_inc;
                    end
                end else if (bus.i_invalid_instruction || (bus.i_ld && bus.i_st)) begin
                    // A simultaneous load and store decode is not a legal instruction
                    w_state_nxt = ST_TRAP;
                    w_cause_nxt = CAUSE_INVALID;
                end else if (bus.i_ld) begin
                    w_state_nxt = ST_WAIT_LOAD;
                end else if (bus.i_st) begin
                    w_state_nxt = ST_WAIT_STORE;
                end else begin
                    w_state_nxt = ST_DO;
                    w_exec_nxt  = bus.i_alu_cycles;
                end
            end

            ST_WAIT_LOAD, ST_WAIT_STORE: begin
                if (bus.i_data_segv) begin
                    w_state_nxt = ST_TRAP;
                    w_cause_nxt = CAUSE_DATA_SEG;
                end else if (bus.i_wait_data) begin
                    if (w_tmo_hit) begin
                        w_state_nxt = ST_TRAP;
                        w_cause_nxt = CAUSE_DATA_TMO;
                    end else begin
                        w_tmo_nxt = w_tmo_inc;
                    end
                end else begin
                    w_state_nxt = ST_DO;
                    w_exec_nxt  = '0;
                end
            end

            ST_DO: begin
                if (r_exec_cnt != '0) begin
                    w_exec_nxt = r_exec_cnt - CYC_W'(1);
                end else begin
                    // Retire; halt is only honoured here at the instruction boundary
                    w_count_nxt = r_instr_count + CNT_W'(1);
                    w_state_nxt = bus.i_halt ? ST_HALT : ST_READ_INS;
                end
            end

            ST_TRAP: begin
                if (bus.i_trap_ack) begin
                    w_state_nxt = ST_HALT;
                end
            end

            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    // Moore output decode from registered state only
    always_comb begin
        w_retire = (r_state == ST_DO) && (r_exec_cnt == '0);
    end

    assign bus.o_state        = r_state;
    assign bus.o_fetch_en     = (r_state == ST_READ_INS);
    assign bus.o_ld_en        = (r_state == ST_WAIT_LOAD);
    assign bus.o_st_en        = (r_state == ST_WAIT_STORE);
    assign bus.o_pc_inc       = w_retire;
    assign bus.o_reg_write_en = w_retire;
    assign bus.o_busy         = (r_state != ST_HALT) && (r_state != ST_TRAP);
    assign bus.o_trap_cause   = r_trap_cause;
    assign bus.o_instr_count  = r_instr_count;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed and randomized checks of exec_sequencer against a phase-level model
module tb_exec_sequencer;

    localparam int CYC_W  = 3;
    localparam int CNT_W  = 4;
    localparam int TMO    = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    exec_sequencer_if #(.CYC_W(CYC_W), .CNT_W(CNT_W)) bus ();

    exec_sequencer #(
        .CYC_W      (CYC_W),
        .TIMEOUT_W  (8),
        .TIMEOUT_MAX(TMO),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the machine is doing, not how it is encoded
    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_MEM   = 2;
    localparam int PH_EXEC  = 3;
    localparam int PH_TRAP  = 4;

    int m_ph    = PH_IDLE;
    bit m_store = 1'b0;
    int m_wait  = 0;
    int m_left  = 0;
    int m_cause = 0;
    int m_ret   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic go_trap(input int cause);
        m_ph    = PH_TRAP;
        m_cause = cause;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample
    task automatic model_step();
        if (reset) begin
            m_ph = PH_IDLE; m_cause = 0; m_ret = 0; m_wait = 0; m_left = 0;
        end else begin
            case (m_ph)
                PH_IDLE: if (bus.i_go && !bus.i_halt) begin
                    m_ph = PH_FETCH; m_cause = 0; m_wait = 0;
                end
                PH_FETCH: begin
                    if (bus.i_instr_segv) go_trap(1);
                    else if (bus.i_wait_instr) begin
                        m_wait++;
                        if (m_wait >= TMO) go_trap(4);
                    end
                    else if (bus.i_invalid_instruction || (bus.i_ld && bus.i_st)) go_trap(3);
                    else if (bus.i_ld) begin m_ph = PH_MEM; m_store = 1'b0; m_wait = 0; end
                    else if (bus.i_st) begin m_ph = PH_MEM; m_store = 1'b1; m_wait = 0; end
                    else begin m_ph = PH_EXEC; m_left = int'(bus.i_alu_cycles); end
                end
                PH_MEM: begin
                    if (bus.i_data_segv) go_trap(2);
                    else if (bus.i_wait_data) begin
                        m_wait++;
                        if (m_wait >= TMO) go_trap(5);
                    end
                    else begin m_ph = PH_EXEC; m_left = 0; end
                end
                PH_EXEC: begin
                    if (m_left > 0) m_left--;
                    else begin
                        m_ret++;
                        m_ph   = bus.i_halt ? PH_IDLE : PH_FETCH;
                        m_wait = 0;
                    end
                end
                default: if (bus.i_trap_ack) m_ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic compare_outputs();
        logic [4:0] exp_state;
        logic       retire;
        logic [5:0] exp_strobes;
        case (m_ph)
            PH_IDLE:  exp_state = 5'b00000;
            PH_FETCH: exp_state = 5'b01000;
            PH_MEM:   exp_state = m_store ? 5'b01100 : 5'b01010;
            PH_EXEC:  exp_state = 5'b01001;
            default:  exp_state = 5'b10000;
        endcase
        retire = (m_ph == PH_EXEC) && (m_left == 0);
        exp_strobes = {m_ph == PH_FETCH, m_ph == PH_MEM && !m_store, m_ph == PH_MEM && m_store,
                       retire, retire, m_ph != PH_IDLE && m_ph != PH_TRAP};
        check("state", 32'(bus.o_state), 32'(exp_state));
        check("strobes", 32'({bus.o_fetch_en, bus.o_ld_en, bus.o_st_en, bus.o_pc_inc,
                              bus.o_reg_write_en, bus.o_busy}), 32'(exp_strobes));
        check("trap_cause", 32'(bus.o_trap_cause), 32'(m_cause));
        check("instr_count", 32'(bus.o_instr_count), 32'(m_ret % (1 << CNT_W)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic clear_inputs();
        bus.i_go = 0; bus.i_halt = 0; bus.i_wait_instr = 0; bus.i_instr_segv = 0;
        bus.i_wait_data = 0; bus.i_data_segv = 0; bus.i_invalid_instruction = 0;
        bus.i_ld = 0; bus.i_st = 0; bus.i_alu_cycles = '0; bus.i_trap_ack = 0;
    endtask

    int n_ld;
    int n_do;
    int n_pc;

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Back-to-back zero-wait ALU instructions
        bus.i_go = 1; tick(); bus.i_go = 0;
        repeat (6) tick();
        check("alu_retired", 32'(bus.o_instr_count), 32'd3);

        // Load held off by wait_data for four cycles
        bus.i_ld = 1; bus.i_wait_data = 1; tick(); bus.i_ld = 0;
        n_ld = int'(bus.o_ld_en);
        repeat (4) begin tick(); n_ld += int'(bus.o_ld_en); end
        bus.i_wait_data = 0; tick();
        check("ld_en_cycles", 32'(n_ld), 32'd5);
        check("load_pc_inc", 32'(bus.o_pc_inc), 32'd1);

        // Multi-cycle ALU instruction
        tick();
        bus.i_alu_cycles = 3'd2; tick(); bus.i_alu_cycles = '0;
        n_do = int'(bus.o_state == 5'b01001); n_pc = int'(bus.o_pc_inc);
        repeat (2) begin tick(); n_do += int'(bus.o_state == 5'b01001); n_pc += int'(bus.o_pc_inc); end
        check("do_cycles", 32'(n_do), 32'd3);
        check("do_pc_pulses", 32'(n_pc), 32'd1);
        tick();

        // Fetch timeout, acknowledge, restart clears cause
        bus.i_wait_instr = 1; repeat (TMO) tick(); bus.i_wait_instr = 0;
        check("tmo_state", 32'(bus.o_state), 32'h10);
        check("tmo_cause", 32'(bus.o_trap_cause), 32'd4);
        bus.i_go = 1; tick(); bus.i_go = 0;
        check("go_in_trap", 32'(bus.o_state), 32'h10);
        bus.i_trap_ack = 1; tick(); bus.i_trap_ack = 0;
        bus.i_go = 1; tick(); bus.i_go = 0;
        check("cause_cleared", 32'(bus.o_trap_cause), 32'd0);

        // data_segv beats wait_data in WAIT_STORE
        bus.i_st = 1; tick(); bus.i_st = 0;
        bus.i_data_segv = 1; bus.i_wait_data = 1; tick();
        bus.i_data_segv = 0; bus.i_wait_data = 0;
        check("dsegv_cause", 32'(bus.o_trap_cause), 32'd2);
        bus.i_trap_ack = 1; tick(); bus.i_trap_ack = 0;
        bus.i_go = 1; tick(); bus.i_go = 0;

        // instr_segv beats invalid_instruction
        bus.i_instr_segv = 1; bus.i_invalid_instruction = 1; tick();
        bus.i_instr_segv = 0; bus.i_invalid_instruction = 0;
        check("isegv_cause", 32'(bus.o_trap_cause), 32'd1);
        bus.i_trap_ack = 1; tick(); bus.i_trap_ack = 0;
        bus.i_go = 1; tick(); bus.i_go = 0;

        // halt during a load wait lets the load retire first
        bus.i_ld = 1; tick(); bus.i_ld = 0;
        bus.i_wait_data = 1; bus.i_halt = 1; repeat (2) tick();
        bus.i_wait_data = 0; tick();
        check("halt_load_pc", 32'(bus.o_pc_inc), 32'd1);
        tick();
        check("halt_reached", 32'(bus.o_state), 32'd0);
        bus.i_go = 1; tick();
        check("halt_go_stay", 32'(bus.o_state), 32'd0);
        bus.i_go = 0; bus.i_halt = 0;

        // Reset during a multi-cycle DO
        bus.i_go = 1; tick(); bus.i_go = 0;
        bus.i_alu_cycles = 3'd3; tick(); bus.i_alu_cycles = '0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_do_state", 32'(bus.o_state), 32'd0);
        check("rst_do_count", 32'(bus.o_instr_count), 32'd0);

        // Sixteen retires wrap a 4-bit counter
        bus.i_go = 1; tick(); bus.i_go = 0;
        repeat (32) tick();
        check("count_wrap", 32'(bus.o_instr_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset                     = ($urandom_range(199) == 0);
            bus.i_go                  = ($urandom_range(99) < 50);
            bus.i_halt                = ($urandom_range(99) < 10);
            bus.i_wait_instr          = ($urandom_range(99) < 30);
            bus.i_instr_segv          = ($urandom_range(99) < 3);
            bus.i_wait_data           = ($urandom_range(99) < 40);
            bus.i_data_segv           = ($urandom_range(99) < 3);
            bus.i_invalid_instruction = ($urandom_range(99) < 3);
            bus.i_ld                  = ($urandom_range(99) < 25);
            bus.i_st                  = ($urandom_range(99) < 25);
            bus.i_alu_cycles          = CYC_W'($urandom_range(7));
            bus.i_trap_ack            = ($urandom_range(99) < 30);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
